// File: rtl/seq_addsub_if.sv
// Handshake and data bundle for the sequential adder/subtractor.
// The master side issues start/m/a/b; the slave side returns status and result.
interface seq_addsub_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, m, a, b,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, m, a, b,
    output busy, done, sum, cout, ovf, zero
  );

endinterface

// File: rtl/seq_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Works DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple slice, so
// an operation takes WIDTH/DIGIT cycles. Subtraction is a + ~b + 1: b is inverted on
// load and the mode bit seeds the carry register.
// WIDTH must be >= 2 and an integer multiple of DIGIT.
module seq_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  seq_addsub_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CNTW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNTW-1:0]  cnt;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  logic [DIGIT-1:0] slice_sum;
  logic [DIGIT:0]   slice_c;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last;
  logic             load;

  // Ripple slice over the low digit of the operand registers, plus result shift.
  always_comb begin
    slice_sum  = '0;
    slice_c    = '0;
    slice_c[0] = carry;
    for (int i = 0; i < int'(DIGIT); i++) begin
      slice_sum[i]   = op_a[i] ^ op_b[i] ^ slice_c[i];
      slice_c[i + 1] = (op_a[i] & op_b[i]) | (slice_c[i] & (op_a[i] ^ op_b[i]));
    end
    // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
    slice_ext = WIDTH'(slice_sum) << (WIDTH - DIGIT);
    acc_next  = (acc >> DIGIT) | slice_ext;
    last      = (cnt == CNTW'(N - 1));
    load      = bus.start && (state != S_RUN);
  end

  // Sequencing and operand/accumulator datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load) begin
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.m}};
            carry <= bus.m;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          acc   <= acc_next;
          carry <= slice_c[DIGIT];
          cnt   <= cnt + CNTW'(1);
          if (last) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result and flags are committed only on the edge that finishes the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (state == S_RUN && last) begin
      sum_r  <= acc_next;
      cout_r <= slice_c[DIGIT];
      // Within the last digit, slice bit DIGIT-1 is operand bit WIDTH-1.
      ovf_r  <= slice_c[DIGIT] ^ slice_c[DIGIT-1];
      zero_r <= (acc_next == '0);
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
  assign bus.zero = zero_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: an 8/2 instance checked every cycle against a cycle-count
// model, plus 4/1 and 8/8 instances checked per operation.
module tb_seq_addsub;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   cmp_en;

  seq_addsub_if #(.WIDTH(8)) bus8 ();
  seq_addsub_if #(.WIDTH(4)) bus4 ();
  seq_addsub_if #(.WIDTH(8)) bus1 ();

  seq_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_addsub #(.WIDTH(8), .DIGIT(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {cout, ovf, zero, sum} from integer semantics.
  function automatic logic [34:0] ref_op(input int w, input logic md,
                                         input logic [31:0] x, input logic [31:0] y);
    longint full, mask, half, ux, uy, sx, sy, ts, raw;
    logic   c, o, z;
    full = longint'(1) << w;
    mask = full - 1;
    half = full >> 1;
    ux   = {32'b0, x} & mask;
    uy   = {32'b0, y} & mask;
    sx   = (ux >= half) ? ux - full : ux;
    sy   = (uy >= half) ? uy - full : uy;
    ts   = md ? sx - sy : sx + sy;
    o    = (ts >= half) || (ts < -half);
    raw  = md ? ux - uy : ux + uy;
    c    = md ? (ux >= uy) : (raw > mask);
    z    = ((raw & mask) == 0);
    return {c, o, z, 32'(raw & mask)};
  endfunction

  // Cycle model of the 8/2 instance: accept when idle, report N edges later.
  localparam int N8 = 4;
  logic        mbusy, mdone;
  logic [34:0] mres, mpend;
  int          mleft;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy <= 1'b0;
      mdone <= 1'b0;
      mres  <= '0;
      mleft <= 0;
    end else if (!mbusy && bus8.start) begin
      mpend <= ref_op(8, bus8.m, {24'b0, bus8.a}, {24'b0, bus8.b});
      mleft <= N8;
      mbusy <= 1'b1;
      mdone <= 1'b0;
    end else if (mbusy) begin
      mleft <= mleft - 1;
      if (mleft == 1) begin
        mbusy <= 1'b0;
        mdone <= 1'b1;
        mres  <= mpend;
      end
    end else begin
      mdone <= 1'b0;
    end
  end

  // Compare the 8/2 instance against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {63'b0, bus8.busy}, {63'b0, mbusy});
      chk("done", {63'b0, bus8.done}, {63'b0, mdone});
      chk("sum", {56'b0, bus8.sum}, {56'b0, mres[7:0]});
      chk("cout", {63'b0, bus8.cout}, {63'b0, mres[34]});
      chk("ovf", {63'b0, bus8.ovf}, {63'b0, mres[33]});
      chk("zero", {63'b0, bus8.zero}, {63'b0, mres[32]});
    end
  end

  task automatic op8(input logic md, input logic [7:0] x, input logic [7:0] y,
                     output logic [34:0] got, output int lat);
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.m = md; bus8.a = x; bus8.b = y;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.m = 1'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    lat = 0;
    while (!bus8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus8.cout, bus8.ovf, bus8.zero, 24'b0, bus8.sum};
  endtask

  task automatic op4(input logic md, input logic [3:0] x, input logic [3:0] y,
                     output logic [34:0] got, output int lat);
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.m = md; bus4.a = x; bus4.b = y;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.a = 4'($urandom); bus4.b = 4'($urandom);
    lat = 0;
    while (!bus4.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus4.cout, bus4.ovf, bus4.zero, 28'b0, bus4.sum};
  endtask

  task automatic op1(input logic md, input logic [7:0] x, input logic [7:0] y,
                     output logic [34:0] got, output int lat);
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.m = md; bus1.a = x; bus1.b = y;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    lat = 0;
    while (!bus1.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = {bus1.cout, bus1.ovf, bus1.zero, 24'b0, bus1.sum};
  endtask

  initial begin
    logic [34:0] got;
    logic [7:0]  x, y;
    logic        md;
    int          lat, gap, ndone;

    checks = 0; errors = 0; cmp_en = 1'b0; rst = 1'b0;
    bus8.start = 0; bus8.m = 0; bus8.a = '0; bus8.b = '0;
    bus4.start = 0; bus4.m = 0; bus4.a = '0; bus4.b = '0;
    bus1.start = 0; bus1.m = 0; bus1.a = '0; bus1.b = '0;
    #2 rst = 1'b1;
    #1 cmp_en = 1'b1;
    chk("rst_busy", {63'b0, bus8.busy}, 64'd0);
    chk("rst_sum", {56'b0, bus8.sum}, 64'd0);
    chk("rst_flags", {61'b0, bus8.cout, bus8.ovf, bus8.zero}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Hand-computed cases.
    op8(1'b1, 8'h08, 8'h0C, got, lat);
    chk("lat_08_0c", 64'(lat), 64'd4);
    chk("res_08_0c", 64'(got), 64'({3'b000, 32'h0000_00FC}));
    op8(1'b1, 8'h03, 8'h03, got, lat);
    chk("res_03_03", 64'(got), 64'({3'b101, 32'h0000_0000}));
    op8(1'b0, 8'hFF, 8'h01, got, lat);
    chk("res_ff_01", 64'(got), 64'({3'b101, 32'h0000_0000}));
    op8(1'b0, 8'h7F, 8'h01, got, lat);
    chk("res_7f_01", 64'(got), 64'({3'b010, 32'h0000_0080}));
    op8(1'b1, 8'h80, 8'h01, got, lat);
    chk("res_80_01", 64'(got), 64'({3'b110, 32'h0000_007F}));

    // start pulsed mid-run with other operands must be ignored.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.m = 1'b0; bus8.a = 8'h21; bus8.b = 8'h12;
    @(posedge clk); #1 bus8.start = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.m = 1'b1; bus8.a = 8'h99; bus8.b = 8'h44;
    @(posedge clk); #1 bus8.start = 1'b0;
    lat = 2;
    while (!bus8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", 64'(lat), 64'd4);
    chk("ign_sum", {56'b0, bus8.sum}, 64'h33);

    // start held through done: second operation lands N+1 cycles after the first.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.m = 1'b0; bus8.a = 8'h11; bus8.b = 8'h22;
    @(posedge clk); #1;
    lat = 0;
    while (!bus8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd4);
    chk("b2b_sum1", {56'b0, bus8.sum}, 64'h33);
    bus8.m = 1'b1; bus8.a = 8'h40; bus8.b = 8'h05;
    gap = 0;
    while (gap < 40) begin
      @(posedge clk); #1;
      gap++;
      if (gap == 1) begin
        bus8.start = 1'b0;
        chk("b2b_busy", {63'b0, bus8.busy}, 64'd1);
      end
      if (bus8.done) break;
    end
    chk("b2b_period", 64'(gap), 64'd5);
    chk("b2b_res2", {61'b0, bus8.cout, bus8.ovf, bus8.zero, 56'b0, bus8.sum},
        {3'b100, 56'b0, 8'h3B} >> 0);

    // Reset mid-run clears everything at once and produces no done.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.m = 1'b0; bus8.a = 8'h55; bus8.b = 8'h0A;
    @(posedge clk); #1 bus8.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {62'b0, bus8.busy, bus8.done}, 64'd0);
    chk("mid_rst_sum", {56'b0, bus8.sum}, 64'd0);
    chk("mid_rst_flags", {61'b0, bus8.cout, bus8.ovf, bus8.zero}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus8.done) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    op8(1'b1, 8'h10, 8'h20, got, lat);
    chk("post_rst_lat", 64'(lat), 64'd4);
    chk("post_rst_res", 64'(got), 64'({3'b000, 32'h0000_00F0}));

    // Randomized operations on the 8/2 instance.
    for (int i = 0; i < 150; i++) begin
      md = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      if (i % 10 == 0) x = y;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op8(md, x, y, got, lat);
      chk("rnd8_lat", 64'(lat), 64'd4);
      chk("rnd8_res", 64'(got), 64'(ref_op(8, md, {24'b0, x}, {24'b0, y})));
    end

    // 4-bit, one bit per cycle.
    op4(1'b1, 4'b0111, 4'b1011, got, lat);
    chk("w4_lat", 64'(lat), 64'd4);
    chk("w4_res", 64'(got), 64'({3'b010, 32'h0000_000C}));
    for (int i = 0; i < 30; i++) begin
      md = 1'($urandom); x = 8'($urandom_range(0, 15)); y = 8'($urandom_range(0, 15));
      op4(md, x[3:0], y[3:0], got, lat);
      chk("rnd4_lat", 64'(lat), 64'd4);
      chk("rnd4_res", 64'(got), 64'(ref_op(4, md, {24'b0, x}, {24'b0, y})));
    end

    // Whole word in one cycle.
    op1(1'b0, 8'h7F, 8'h01, got, lat);
    chk("w8d8_lat", 64'(lat), 64'd1);
    chk("w8d8_res", 64'(got), 64'({3'b010, 32'h0000_0080}));
    for (int i = 0; i < 30; i++) begin
      md = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      op1(md, x, y, got, lat);
      chk("rnd1_lat", 64'(lat), 64'd1);
      chk("rnd1_res", 64'(got), 64'(ref_op(8, md, {24'b0, x}, {24'b0, y})));
    end

    repeat (3) @(posedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit two's-complement add or subtract DIGIT bits per clock, LSB digit first, through a DIGIT-bit ripple slice of full-adder cells. Subtraction inverts b and injects m as carry-in. Sits beside the combinational ripple adder-subtractors as the area-reduced, registered arithmetic unit, with a start/busy/done handshake and status flags.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT cycles per operation.
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; accepted on a rising edge of clk when busy=0.
- m  input  1  mode, sampled with start: 0 = a+b, 1 = a−b (a + ~b + 1).
- a  input  WIDTH  operand, sampled with start.
- b  input  WIDTH  operand, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0, zero=0; digit counter and internal registers cleared.
- IDLE or DONE with start=1 at an edge:
  - Latch a into operand register A and b^{WIDTH{m}} into operand register B.
  - Carry register = m.
  - Counter = 0, state=RUN, busy=1, done=0.
- RUN, each edge:
  - Add the low DIGIT bits of A and B plus the carry register through the ripple slice.
  - Shift the DIGIT-bit result into the top of the result shift register; shift A and B right by DIGIT.
  - Carry register = slice carry-out. Counter increments.
- On the edge that processes digit N−1:
  - Commit sum, cout, ovf, zero to the outputs.
  - ovf uses the carry into and out of bit WIDTH−1 within the last digit.
  - state=DONE, busy=0, done=1.
- DONE without start: next edge goes to IDLE, done=0.
- Outputs sum, cout, ovf, zero change only on a commit edge or reset. They hold their values through IDLE and the next RUN.
- start while busy=1 is ignored; no queuing. a, b and m may change freely during RUN.
- start in DONE is accepted (back-to-back). done falls and busy rises on that edge.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Start accepted at edge E0. busy=1 after E0; done=1 and valid outputs after edge E0+N; done=0 after E0+N+1 unless a new start is accepted there.
- Latency from start edge to done is N cycles. Maximum throughput is one operation per N+1 cycles.
- DIGIT=WIDTH gives N=1: done is asserted the cycle after start.
- rst asserted mid-RUN aborts immediately. No done pulse; outputs return to 0.
- The slice critical path is DIGIT full-adder carry stages. No path depends on WIDTH other than counter decode.

## Test plan
- WIDTH=8, DIGIT=2, m=1, a=0x08, b=0x0C -> done exactly 4 cycles after the start edge; sum=0xFC, cout=0, ovf=0, zero=0.
- m=1, a=0x03, b=0x03 -> sum=0x00, cout=1, ovf=0, zero=1. Then m=0, a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0, zero=1.
- m=0, a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then m=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=4, DIGIT=1, m=1, a=4'b0111, b=4'b1011 -> done after 4 cycles; sum=4'b1100, cout=0, ovf=1.
- start pulsed with new operands mid-RUN -> ignored; original result is reported. start held high in DONE -> second operation completes N cycles later, giving a period of N+1.
- rst asserted for one cycle mid-RUN -> busy, done and all result outputs are 0 immediately. No done pulse follows. The next start completes normally.
